// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, latencies
// and the FSM state encoding.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'b0000;
  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MFHI  = 4'b0101;
  localparam logic [3:0] OP_MFLO  = 4'b0110;
  localparam logic [3:0] OP_MTHI  = 4'b0111;
  localparam logic [3:0] OP_MTLO  = 4'b1000;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers. The result is computed at launch
// and held in pending registers until the fixed latency has elapsed.
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUop,
  input  logic [31:0] ScrA,
  input  logic [31:0] ScrB,
  output logic [31:0] MDUout,
  output logic        busy
);

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;

  logic        launch;
  logic [3:0]  lat;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign busy   = (state == RUN);
  assign launch = start && (state == IDLE) &&
                  (MDUop == OP_MULT || MDUop == OP_MULTU ||
                   MDUop == OP_DIV  || MDUop == OP_DIVU);

  assign prod_s = $signed({{32{ScrA[31]}}, ScrA}) * $signed({{32{ScrB[31]}}, ScrB});
  assign prod_u = {32'b0, ScrA} * {32'b0, ScrB};

  // A divide by zero latches the current HI/LO so the later commit is a no-op;
  // the most-negative / -1 case is pinned explicitly rather than left to the operator.
  always_comb begin
    calc_hi = hi;
    calc_lo = lo;
    lat     = 4'd0;
    case (MDUop)
      OP_MULT: begin
        calc_hi = prod_s[63:32];
        calc_lo = prod_s[31:0];
        lat     = 4'(MULT_LAT);
      end
      OP_MULTU: begin
        calc_hi = prod_u[63:32];
        calc_lo = prod_u[31:0];
        lat     = 4'(MULT_LAT);
      end
      OP_DIV: begin
        lat = 4'(DIV_LAT);
        if (ScrB != 32'd0) begin
          if (ScrA == 32'h8000_0000 && ScrB == 32'hFFFF_FFFF) begin
            calc_lo = 32'h8000_0000;
            calc_hi = 32'd0;
          end else begin
            calc_lo = $signed(ScrA) / $signed(ScrB);
            calc_hi = $signed(ScrA) % $signed(ScrB);
          end
        end
      end
      OP_DIVU: begin
        lat = 4'(DIV_LAT);
        if (ScrB != 32'd0) begin
          calc_lo = ScrA / ScrB;
          calc_hi = ScrA % ScrB;
        end
      end
      default: begin
        lat = 4'd0;
      end
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (launch) next_state = RUN;
      RUN:  if (cnt == 4'd1) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // HI/LO writes from MTHI/MTLO are only honoured while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      cnt     <= 4'd0;
    end else if (state == IDLE) begin
      if (launch) begin
        pend_hi <= calc_hi;
        pend_lo <= calc_lo;
        cnt     <= lat;
      end else if (MDUop == OP_MTHI) begin
        hi <= ScrA;
      end else if (MDUop == OP_MTLO) begin
        lo <= ScrA;
      end
    end else begin
      if (cnt == 4'd1) begin
        hi  <= pend_hi;
        lo  <= pend_lo;
        cnt <= 4'd0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    MDUout = 32'd0;
    if (MDUop == OP_MFHI)      MDUout = hi;
    else if (MDUop == OP_MFLO) MDUout = lo;
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios plus randomized operations
// checked against an arithmetic reference model of HI/LO.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  MDUop;
  logic [31:0] ScrA;
  logic [31:0] ScrB;
  logic [31:0] MDUout;
  logic        busy;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] expHi;
  logic [31:0] expLo;

  mdu dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .MDUop  (MDUop),
    .ScrA   (ScrA),
    .ScrB   (ScrB),
    .MDUout (MDUout),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: HI/LO after an operation, from plain 64-bit arithmetic.
  task automatic modelOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r, p;
    longint unsigned pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  begin p = sa * sb; expHi = p[63:32]; expLo = p[31:0]; end
      OP_MULTU: begin
        pu = longint'(a) * longint'(b);
        expHi = pu[63:32]; expLo = pu[31:0];
      end
      OP_DIV: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        expLo = q[31:0]; expHi = r[31:0];
      end
      OP_DIVU: if (b != 0) begin expLo = a / b; expHi = a % b; end
      OP_MTHI: expHi = a;
      OP_MTLO: expLo = a;
      default: ;
    endcase
  endtask

  function automatic int expLatency(input logic [3:0] op);
    if (op == OP_MULT || op == OP_MULTU) return 5;
    if (op == OP_DIV || op == OP_DIVU)   return 10;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readReg(input logic [3:0] op, output logic [31:0] v);
    logic [3:0] saved;
    saved = MDUop;
    MDUop = op;
    #1;
    v = MDUout;
    MDUop = saved;
  endtask

  // Launches an operation and counts busy cycles (bounded).
  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cycles);
    start = 1'b1; MDUop = op; ScrA = a; ScrB = b;
    tick();
    start = 1'b0; MDUop = OP_NONE;
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      tick();
    end
  endtask

  task automatic writeReg(input logic [3:0] op, input logic [31:0] a);
    MDUop = op; ScrA = a;
    tick();
    MDUop = OP_NONE;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; start = 1'b0; MDUop = OP_NONE; ScrA = 0; ScrB = 0;
    tick(); tick();
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL reset_busy got %b want 0", busy);
    end
    readReg(OP_MFHI, v);
    testsRun++;
    if (v !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_hi got %h want 0", v); end
    readReg(OP_MFLO, v);
    testsRun++;
    if (v !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_lo got %h want 0", v); end
    reset = 1'b0;
    tick();
    expHi = 0; expLo = 0;
  endtask

  task automatic test_mult_example();
    int c; logic [31:0] v;
    runOp(OP_MULT, 32'hFFFF_FFFE, 32'd3, c);
    testsRun++;
    if (c != 5) begin testsFailed++; $display("[TB] FAIL mult_busy got %0d want 5", c); end
    readReg(OP_MFHI, v);
    testsRun++;
    if (v !== 32'hFFFF_FFFF) begin testsFailed++; $display("[TB] FAIL mult_hi got %h want ffffffff", v); end
    readReg(OP_MFLO, v);
    testsRun++;
    if (v !== 32'hFFFF_FFFA) begin testsFailed++; $display("[TB] FAIL mult_lo got %h want fffffffa", v); end
    readReg(OP_NONE, v);
    testsRun++;
    if (v !== 32'd0) begin testsFailed++; $display("[TB] FAIL none_read got %h want 0", v); end
    expHi = 32'hFFFF_FFFF; expLo = 32'hFFFF_FFFA;
  endtask

  task automatic test_div_example();
    int c; logic [31:0] v;
    runOp(OP_DIV, 32'hFFFF_FFF9, 32'd2, c);
    testsRun++;
    if (c != 10) begin testsFailed++; $display("[TB] FAIL div_busy got %0d want 10", c); end
    readReg(OP_MFLO, v);
    testsRun++;
    if (v !== 32'hFFFF_FFFD) begin testsFailed++; $display("[TB] FAIL div_lo got %h want fffffffd", v); end
    readReg(OP_MFHI, v);
    testsRun++;
    if (v !== 32'hFFFF_FFFF) begin testsFailed++; $display("[TB] FAIL div_hi got %h want ffffffff", v); end
    runOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, c);
    readReg(OP_MFLO, v);
    testsRun++;
    if (v !== 32'h8000_0000) begin testsFailed++; $display("[TB] FAIL div_ovf_lo got %h want 80000000", v); end
    readReg(OP_MFHI, v);
    testsRun++;
    if (v !== 32'd0) begin testsFailed++; $display("[TB] FAIL div_ovf_hi got %h want 0", v); end
    expHi = 32'd0; expLo = 32'h8000_0000;
  endtask

  task automatic test_divzero();
    int c; logic [31:0] v;
    writeReg(OP_MTLO, 32'h0000_1234);
    writeReg(OP_MTHI, 32'h0000_5678);
    runOp(OP_DIVU, 32'hDEAD_BEEF, 32'd0, c);
    testsRun++;
    if (c != 10) begin testsFailed++; $display("[TB] FAIL divz_busy got %0d want 10", c); end
    readReg(OP_MFLO, v);
    testsRun++;
    if (v !== 32'h0000_1234) begin testsFailed++; $display("[TB] FAIL divz_lo got %h want 00001234", v); end
    readReg(OP_MFHI, v);
    testsRun++;
    if (v !== 32'h0000_5678) begin testsFailed++; $display("[TB] FAIL divz_hi got %h want 00005678", v); end
    expHi = 32'h0000_5678; expLo = 32'h0000_1234;
  endtask

  // Second start in busy cycle 2, reads and MTLO during busy.
  task automatic test_busy_behaviour();
    int c; logic [31:0] v;
    start = 1'b1; MDUop = OP_MULTU; ScrA = 32'd1000; ScrB = 32'd7;
    tick();
    start = 1'b0; MDUop = OP_NONE;
    c = 0;
    while (busy && c < 40) begin
      c++;
      if (c == 2) begin
        start = 1'b1; MDUop = OP_MULT; ScrA = 32'd9; ScrB = 32'd9;
      end else if (c == 3) begin
        start = 1'b0; MDUop = OP_NONE;
        readReg(OP_MFLO, v);
        testsRun++;
        if (v !== expLo) begin testsFailed++; $display("[TB] FAIL busy_read got %h want %h", v, expLo); end
        MDUop = OP_MTLO; ScrA = 32'hBAD0_BAD0;
      end else begin
        start = 1'b0; MDUop = OP_NONE;
      end
      tick();
    end
    MDUop = OP_NONE;
    testsRun++;
    if (c != 5) begin testsFailed++; $display("[TB] FAIL restart_busy got %0d want 5", c); end
    readReg(OP_MFLO, v);
    testsRun++;
    if (v !== 32'd7000) begin testsFailed++; $display("[TB] FAIL restart_lo got %h want 00001b58", v); end
    readReg(OP_MFHI, v);
    testsRun++;
    if (v !== 32'd0) begin testsFailed++; $display("[TB] FAIL restart_hi got %h want 0", v); end
    expHi = 0; expLo = 32'd7000;
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    start = 1'b1; MDUop = OP_MULTU; ScrA = 32'hFFFF_FFFF; ScrB = 32'hFFFF_FFFF;
    tick();
    start = 1'b0; MDUop = OP_NONE;
    tick(); tick();
    reset = 1'b1;
    #1;
    testsRun++;
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_busy got %b want 0", busy); end
    readReg(OP_MFHI, v);
    testsRun++;
    if (v !== 32'd0) begin testsFailed++; $display("[TB] FAIL rstmid_hi got %h want 0", v); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    testsRun++;
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_late_busy got %b want 0", busy); end
    readReg(OP_MFLO, v);
    testsRun++;
    if (v !== 32'd0) begin testsFailed++; $display("[TB] FAIL rstmid_lo got %h want 0", v); end
    readReg(OP_MFHI, v);
    testsRun++;
    if (v !== 32'd0) begin testsFailed++; $display("[TB] FAIL rstmid_late_hi got %h want 0", v); end
    expHi = 0; expLo = 0;
  endtask

  task automatic test_random();
    int c;
    logic [3:0] op;
    logic [31:0] a, b, v;
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom();
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom();
      endcase
      if (expLatency(op) != 0) begin
        runOp(op, a, b, c);
        modelOp(op, a, b);
        testsRun++;
        if (c != expLatency(op)) begin
          testsFailed++; $display("[TB] FAIL rand_busy op=%0d got %0d want %0d", op, c, expLatency(op));
        end
      end else begin
        start = 1'($urandom_range(0, 1)); MDUop = op; ScrA = a; ScrB = b;
        tick();
        start = 1'b0; MDUop = OP_NONE;
        modelOp(op, a, b);
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rand_nolaunch op=%0d busy got %b want 0", op, busy); end
      end
      readReg(OP_MFHI, v);
      testsRun++;
      if (v !== expHi) begin testsFailed++; $display("[TB] FAIL rand_hi op=%0d a=%h b=%h got %h want %h", op, a, b, v, expHi); end
      readReg(OP_MFLO, v);
      testsRun++;
      if (v !== expLo) begin testsFailed++; $display("[TB] FAIL rand_lo op=%0d a=%h b=%h got %h want %h", op, a, b, v, expLo); end
    end
  endtask

  initial begin
    test_reset();
    test_mult_example();
    test_div_example();
    test_divzero();
    test_busy_behaviour();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
